// File: rtl/apb_pkg.sv
// Shared types for the APB4 command master: FSM state encoding, the command
// record for the default 32/32 configuration, and PPROT bit positions.
package apb_pkg;

  // Transfer sequencing: one outstanding transfer, no pipelining.
  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StAccess,
    StResp
  } apb_state_e;

  localparam int unsigned APB_ADDR_W = 32;
  localparam int unsigned APB_DATA_W = 32;

  // Command record as presented by the initiator (default widths).
  typedef struct packed {
    logic                    write;
    logic [APB_ADDR_W-1:0]   addr;
    logic [APB_DATA_W-1:0]   wdata;
    logic [APB_DATA_W/8-1:0] strb;
    logic [2:0]              prot;
  } apb_cmd_t;

  // PPROT bit positions.
  localparam int unsigned PPROT_PRIV_BIT   = 0;
  localparam int unsigned PPROT_NONSEC_BIT = 1;
  localparam int unsigned PPROT_INSTR_BIT  = 2;

endpackage

// File: rtl/apb_cmd_master.sv
// APB4 requester: valid/ready command in, APB SETUP/ACCESS transfer out,
// read data and error status back on a valid/ready response channel.
// Optional feature macro: APB_TIMEOUT_EN bounds the ACCESS phase to
// TIMEOUT_CYCLES cycles and reports a timeout as rsp_slverr=1.
module apb_cmd_master
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                PCLK,
  input  logic                PRESET,
  // Command channel
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_strb,
  input  logic [2:0]          cmd_prot,
  // Response channel
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_slverr,
  // APB4 master side
  output logic                PSEL,
  output logic                PENABLE,
  output logic                PWRITE,
  output logic [ADDR_W-1:0]   PADDR,
  output logic [DATA_W-1:0]   PWDATA,
  output logic [DATA_W/8-1:0] PSTRB,
  output logic [2:0]          PPROT,
  input  logic [DATA_W-1:0]   PRDATA,
  input  logic                PREADY,
  input  logic                PSLVERR
);

  localparam int unsigned STRB_W = DATA_W / 8;
  // Clears the byte-lane bits of the address so PADDR is bus-aligned.
  localparam logic [ADDR_W-1:0] ADDR_MASK = ~(ADDR_W'(STRB_W - 1));

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("apb_cmd_master: TIMEOUT_CYCLES must be >= 2");
  end
  if (DATA_W != 8 && DATA_W != 16 && DATA_W != 32) begin : g_bad_data_w
    $error("apb_cmd_master: DATA_W must be 8, 16 or 32");
  end

  apb_state_e state;

`ifdef APB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
  // Counter value seen during the final allowed ACCESS cycle.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] tmo_cnt;
`endif

  // Transfer FSM with all outputs registered; APB address/control/data hold
  // the last accepted command until the next one is accepted.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state      <= StIdle;
      cmd_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_slverr <= 1'b0;
      PSEL       <= 1'b0;
      PENABLE    <= 1'b0;
      PWRITE     <= 1'b0;
      PADDR      <= '0;
      PWDATA     <= '0;
      PSTRB      <= '0;
      PPROT      <= '0;
`ifdef APB_TIMEOUT_EN
      tmo_cnt    <= '0;
`endif
    end else begin
      unique case (state)
        StIdle: begin
          if (cmd_valid) begin
            PADDR     <= cmd_addr & ADDR_MASK;
            PWRITE    <= cmd_write;
            PWDATA    <= cmd_wdata;
            // Reads must present an all-zero strobe.
            PSTRB     <= cmd_write ? cmd_strb : '0;
            PPROT     <= cmd_prot;
            PSEL      <= 1'b1;
            cmd_ready <= 1'b0;
            state     <= StSetup;
`ifdef APB_TIMEOUT_EN
            tmo_cnt   <= '0;
`endif
          end
        end

        StSetup: begin
          PENABLE <= 1'b1;
          state   <= StAccess;
        end

        StAccess: begin
          if (PREADY) begin
            PSEL       <= 1'b0;
            PENABLE    <= 1'b0;
            rsp_valid  <= 1'b1;
            rsp_slverr <= PSLVERR;
            // Only a successful read returns data.
            rsp_rdata  <= (!PWRITE && !PSLVERR) ? PRDATA : '0;
            state      <= StResp;
          end
`ifdef APB_TIMEOUT_EN
          else if (tmo_cnt == CNT_LAST) begin
            PSEL       <= 1'b0;
            PENABLE    <= 1'b0;
            rsp_valid  <= 1'b1;
            rsp_slverr <= 1'b1;
            rsp_rdata  <= '0;
            state      <= StResp;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end

        StResp: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= StIdle;
          end
        end

        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Self-checking bench for apb_cmd_master (ADDR_W=32, DATA_W=32).
// Expected transfers and responses come from a transaction-level model of
// the command -> APB -> response rules; timing is checked cycle by cycle.
module tb_apb_cmd_master;
  import apb_pkg::*;

  localparam int unsigned TMO = 8;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_strb;
  logic [2:0]  cmd_prot;
  logic        rsp_valid, rsp_ready, rsp_slverr;
  logic [31:0] rsp_rdata;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic [3:0]  PSTRB;
  logic [2:0]  PPROT;
  logic        PREADY, PSLVERR;

  int checks = 0;
  int errors = 0;

  apb_cmd_master #(
    .ADDR_W        (32),
    .DATA_W        (32),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .PCLK      (PCLK),
    .PRESET    (PRESET),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .cmd_strb  (cmd_strb),
    .cmd_prot  (cmd_prot),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_slverr(rsp_slverr),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
    .PSTRB     (PSTRB),
    .PPROT     (PPROT),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY),
    .PSLVERR   (PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; stimulus and sampling happen 1ns after the edge.
  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  // Bus-side inputs that the master must ignore outside ACCESS.
  task automatic garble();
    PREADY  = 1'($urandom);
    PSLVERR = 1'($urandom);
    PRDATA  = $urandom;
  endtask

  // One complete transfer. nwait = ACCESS cycles with PREADY low before
  // completion; hold = cycles rsp_ready stays low in RESP.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] strb, input logic [2:0] prot, input int nwait,
                      input logic [31:0] rdata, input logic serr, input int hold);
    logic [31:0] exp_addr, exp_rdata;
    logic [3:0]  exp_strb;
    int          lat;
    // Model: word-aligned address, zero strobe for reads, data only on a good read.
    exp_addr  = addr - (addr % 4);
    exp_strb  = wr ? strb : 4'h0;
    exp_rdata = (!wr && !serr) ? rdata : 32'h0;

    check("idle_cmd_ready", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    cmd_strb  = strb;
    cmd_prot  = prot;
    garble();
    tick();  // accept edge
    cmd_valid = 1'b0;
    cmd_addr  = $urandom;
    cmd_wdata = $urandom;
    lat = 0;
    check("setup_psel", 32'(PSEL), 32'd1);
    check("setup_penable", 32'(PENABLE), 32'd0);
    check("setup_cmd_ready", 32'(cmd_ready), 32'd0);
    check("paddr", PADDR, exp_addr);
    check("pwrite", 32'(PWRITE), 32'(wr));
    check("pstrb", 32'(PSTRB), 32'(exp_strb));
    check("pprot", 32'(PPROT), 32'(prot));
    if (wr) check("pwdata", PWDATA, wdata);
    garble();
    tick();
    lat++;
    for (int i = 0; i <= nwait; i++) begin
      check("access_psel", 32'(PSEL), 32'd1);
      check("access_penable", 32'(PENABLE), 32'd1);
      check("access_paddr_stable", PADDR, exp_addr);
      check("access_pstrb_stable", 32'(PSTRB), 32'(exp_strb));
      check("access_rsp_valid", 32'(rsp_valid), 32'd0);
      PREADY  = (i == nwait);
      PSLVERR = (i == nwait) ? serr : 1'($urandom);
      PRDATA  = (i == nwait) ? rdata : $urandom;
      tick();
      lat++;
    end
    garble();
    check("rsp_latency", 32'(lat), 32'(2 + nwait));
    check("resp_psel", 32'(PSEL), 32'd0);
    check("resp_penable", 32'(PENABLE), 32'd0);
    check("paddr_hold", PADDR, exp_addr);
    for (int h = 0; h <= hold; h++) begin
      check("rsp_valid", 32'(rsp_valid), 32'd1);
      check("rsp_rdata", rsp_rdata, exp_rdata);
      check("rsp_slverr", 32'(rsp_slverr), 32'(serr));
      check("resp_cmd_ready", 32'(cmd_ready), 32'd0);
      rsp_ready = (h == hold);
      garble();
      tick();
    end
    rsp_ready = 1'b0;
    check("after_rsp_valid", 32'(rsp_valid), 32'd0);
    check("after_cmd_ready", 32'(cmd_ready), 32'd1);
    check("after_psel", 32'(PSEL), 32'd0);
  endtask

  initial begin
    int nw_max;
    logic [2:0] prot_priv;
    prot_priv = '0;
    prot_priv[PPROT_PRIV_BIT] = 1'b1;
    PRESET    = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    cmd_strb  = '0;
    cmd_prot  = '0;
    rsp_ready = 1'b0;
    PREADY    = 1'b0;
    PSLVERR   = 1'b0;
    PRDATA    = '0;
    tick();
    tick();

    // Reset state
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_psel", 32'(PSEL), 32'd0);
    check("rst_penable", 32'(PENABLE), 32'd0);
    check("rst_paddr", PADDR, 32'h0);
    check("rst_pstrb", 32'(PSTRB), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    PRESET = 1'b0;
    tick();

    // Zero-wait write
    xfer(1'b1, 32'h1000, 32'hDEADBEEF, 4'hF, prot_priv, 0, 32'h0, 1'b0, 0);
    // Read with three wait states
    xfer(1'b0, 32'h0004, 32'h0, 4'hF, 3'd0, 3, 32'hCAFE0001, 1'b0, 0);
    // Errored read, response held off for 4 cycles
    xfer(1'b0, 32'h0008, 32'h0, 4'h0, 3'd2, 1, 32'h12345678, 1'b1, 4);
    // Unaligned address, back-to-back
    xfer(1'b1, 32'h1003, 32'h0BADF00D, 4'h3, 3'd5, 0, 32'h0, 1'b0, 0);
    xfer(1'b0, 32'h1007, 32'h0, 4'hF, 3'd7, 0, 32'hA5A5A5A5, 1'b0, 0);
    // Errored write
    xfer(1'b1, 32'h2000, 32'h11112222, 4'h5, 3'd1, 2, 32'hFFFFFFFF, 1'b1, 1);

    // Randomized transfers
`ifdef APB_TIMEOUT_EN
    nw_max = TMO - 2;
`else
    nw_max = 6;
`endif
    for (int t = 0; t < 40; t++) begin
      xfer(1'($urandom), $urandom, $urandom, 4'($urandom), 3'($urandom),
           $urandom_range(0, nw_max), $urandom, ($urandom_range(0, 3) == 0),
           $urandom_range(0, 3));
    end

    // Reset during ACCESS drops the transfer
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 32'h3000;
    PREADY    = 1'b0;
    tick();
    cmd_valid = 1'b0;
    tick();
    check("pre_rst_penable", 32'(PENABLE), 32'd1);
    PRESET = 1'b1;
    tick();
    PRESET = 1'b0;
    PREADY = 1'b1;
    check("midrst_psel", 32'(PSEL), 32'd0);
    check("midrst_penable", 32'(PENABLE), 32'd0);
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
    for (int i = 0; i < 4; i++) tick();
    check("midrst_no_rsp", 32'(rsp_valid), 32'd0);
    check("midrst_no_psel", 32'(PSEL), 32'd0);

`ifdef APB_TIMEOUT_EN
    // PREADY arriving in the last allowed ACCESS cycle completes normally
    xfer(1'b0, 32'h4000, 32'h0, 4'h0, 3'd0, TMO - 1, 32'h5A5A0000, 1'b0, 0);
    // PREADY stuck low: TMO ACCESS cycles, then an error response
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 32'h4004;
    PREADY    = 1'b0;
    PRDATA    = 32'h77777777;
    tick();
    cmd_valid = 1'b0;
    tick();
    for (int i = 0; i < int'(TMO); i++) begin
      check("tmo_access_penable", 32'(PENABLE), 32'd1);
      check("tmo_access_rsp_valid", 32'(rsp_valid), 32'd0);
      tick();
    end
    check("tmo_psel", 32'(PSEL), 32'd0);
    check("tmo_rsp_valid", 32'(rsp_valid), 32'd1);
    check("tmo_slverr", 32'(rsp_slverr), 32'd1);
    check("tmo_rdata", rsp_rdata, 32'h0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("tmo_done_cmd_ready", 32'(cmd_ready), 32'd1);
`else
    // PREADY stuck low: ACCESS persists indefinitely
    begin
      int bad;
      bad = 0;
      cmd_valid = 1'b1;
      cmd_write = 1'b1;
      cmd_addr  = 32'h4004;
      PREADY    = 1'b0;
      tick();
      cmd_valid = 1'b0;
      tick();
      for (int i = 0; i < 1000; i++) begin
        if (!(PSEL && PENABLE && !rsp_valid)) bad++;
        tick();
      end
      check("stuck_access_bad_cycles", 32'(bad), 32'd0);
      check("stuck_psel", 32'(PSEL), 32'd1);
      check("stuck_penable", 32'(PENABLE), 32'd1);
      PRESET = 1'b1;
      tick();
      PRESET = 1'b0;
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
